// File: rtl/hqm_system_mem_ctl_pkg.sv
// Shared types and sizes for the HQM system-memory register-file controllers.
package hqm_system_mem_ctl_pkg;

    localparam int AW     = 8;
    localparam int DWIDTH = 10;
    localparam int DEPTH  = 256;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctl_state_e;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/hqm_system_mem_rr_arb2.sv
// Two-input round-robin arbiter; the pointer only moves when both requesters contend,
// so a lone requester never loses its turn.
module hqm_system_mem_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_comb begin
        // NOTE: default assigned first so every path drives o_gnt and no latch is inferred.
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_req == 2'b11) begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            r_ptr <= ~r_ptr;
        end
    end

endmodule

// File: rtl/hqm_system_mem_rf_256x10_ctl.sv
// Controller for the 256x10 two-port RF: init sweep after reset or cfg_reinit, then
// round-robin write arbitration, a one-cycle read response, and same-address forwarding.
module hqm_system_mem_rf_256x10_ctl
    import hqm_system_mem_ctl_pkg::*;
#(
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_reinit,
    output logic              init_done,
    input  logic              wr0_v,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [DWIDTH-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_v,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [DWIDTH-1:0] wr1_data,
    output logic              wr1_ready,
    input  logic              rd_v,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_ready,
    output logic              rd_rsp_v,
    output logic [DWIDTH-1:0] rd_rsp_data,
    output logic              mem_we,
    output logic [AW-1:0]     mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_re,
    output logic [AW-1:0]     mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata
);

    ctl_state_e        r_state;
    ctl_state_e        w_state_nxt;
    logic [AW:0]       r_cnt;
    logic [AW:0]       w_cnt_nxt;
    logic              r_rsp_v;
    logic              r_byp_sel;
    logic [DWIDTH-1:0] r_byp_data;

    logic              w_init_act;
    logic              w_run;
    logic              w_rd_acc;
    logic              w_wr_act;
    logic              w_coll;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    wr_req_t           w_wr0;
    wr_req_t           w_wr1;
    wr_req_t           w_wr_sel;

    // rst_n gates the sweep so the RF write port stays quiet while reset is held.
    assign w_init_act = rst_n && (r_state == ST_INIT);
    assign w_run      = (r_state == ST_RUN);
    assign init_done  = w_run;

    assign w_wr0    = '{addr: wr0_addr, data: wr0_data};
    assign w_wr1    = '{addr: wr1_addr, data: wr1_data};
    assign w_req    = {wr1_v, wr0_v} & {2{w_run && !cfg_reinit}};
    assign w_wr_sel = w_gnt[1] ? w_wr1 : w_wr0;
    assign w_wr_act = |w_gnt;

    hqm_system_mem_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign wr0_ready = w_gnt[0];
    assign wr1_ready = w_gnt[1];

    assign rd_ready  = w_run && !cfg_reinit;
    assign w_rd_acc  = rd_v && rd_ready;
    assign mem_re    = w_rd_acc;
    assign mem_raddr = w_rd_acc ? rd_addr : '0;

    // The RF gives undefined data on a same-cycle same-address hit, so capture the write instead.
    assign w_coll = w_rd_acc && w_wr_act && (w_wr_sel.addr == rd_addr);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (w_init_act) begin
            mem_we    = 1'b1;
            mem_waddr = r_cnt[AW-1:0];
            mem_wdata = INIT_VAL;
        end else if (w_wr_act) begin
            mem_we    = 1'b1;
            mem_waddr = w_wr_sel.addr;
            mem_wdata = w_wr_sel.data;
        end
    end

    assign rd_rsp_v    = r_rsp_v;
    assign rd_rsp_data = !r_rsp_v ? '0 : (r_byp_sel ? r_byp_data : mem_rdata);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (cfg_reinit) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt[AW-1:0] == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (cfg_reinit) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_rsp_v    <= 1'b0;
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rsp_v   <= w_rd_acc;
            r_byp_sel <= w_coll;
            if (w_coll) begin
                r_byp_data <= w_wr_sel.data;
            end
        end
    end

endmodule

// File: tb/tb_hqm_system_mem_rf_256x10_ctl.sv
// Self-checking bench: directed steps plus random traffic against a behavioural model
// of the controller (expected memory contents, turn-taking, one-cycle read response).
module tb_hqm_system_mem_rf_256x10_ctl;

    localparam logic [9:0] INIT_VAL = 10'h000;

    logic       clk;
    logic       rst_n;
    logic       cfg_reinit;
    logic       init_done;
    logic       wr0_v;
    logic [7:0] wr0_addr;
    logic [9:0] wr0_data;
    logic       wr0_ready;
    logic       wr1_v;
    logic [7:0] wr1_addr;
    logic [9:0] wr1_data;
    logic       wr1_ready;
    logic       rd_v;
    logic [7:0] rd_addr;
    logic       rd_ready;
    logic       rd_rsp_v;
    logic [9:0] rd_rsp_data;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [9:0] mem_wdata;
    logic       mem_re;
    logic [7:0] mem_raddr;
    logic [9:0] mem_rdata;

    hqm_system_mem_rf_256x10_ctl #(.INIT_VAL(INIT_VAL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_reinit  (cfg_reinit),
        .init_done   (init_done),
        .wr0_v       (wr0_v),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr0_ready   (wr0_ready),
        .wr1_v       (wr1_v),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .wr1_ready   (wr1_ready),
        .rd_v        (rd_v),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rd_rsp_v    (rd_rsp_v),
        .rd_rsp_data (rd_rsp_data),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Register file: undefined read data on a same-address read/write in one cycle.
    logic [9:0] rf [256];
    logic [9:0] rf_q;
    always @(posedge clk) begin
        if (mem_we) rf[mem_waddr] <= mem_wdata;
        if (mem_re) rf_q <= (mem_we && mem_waddr == mem_raddr) ? 10'bx : rf[mem_raddr];
    end
    assign mem_rdata = rf_q;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [9:0] exp_mem [256];
    bit         m_run;
    int         m_cnt;
    bit         m_ptr;
    bit         pend_v;
    logic [9:0] pend_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = 0;
        m_ptr  = 1'b0;
        pend_v = 1'b0;
        pend_d = '0;
    endtask

    task automatic reset_checks();
        check("rst_init_done", 32'(init_done),   0);
        check("rst_wr0_ready", 32'(wr0_ready),   0);
        check("rst_wr1_ready", 32'(wr1_ready),   0);
        check("rst_rd_ready",  32'(rd_ready),    0);
        check("rst_rsp_v",     32'(rd_rsp_v),    0);
        check("rst_rsp_data",  32'(rd_rsp_data), 0);
        check("rst_mem_we",    32'(mem_we),      0);
        check("rst_mem_waddr", 32'(mem_waddr),   0);
        check("rst_mem_wdata", 32'(mem_wdata),   0);
        check("rst_mem_re",    32'(mem_re),      0);
        check("rst_mem_raddr", 32'(mem_raddr),   0);
    endtask

    // One clock: apply inputs, check against the model, advance the model, step the clock.
    task automatic drive(input logic w0v, input logic [7:0] w0a, input logic [9:0] w0d,
                         input logic w1v, input logic [7:0] w1a, input logic [9:0] w1d,
                         input logic rv, input logic [7:0] ra, input logic ri);
        bit         g0, g1, rdacc;
        logic [7:0] wa;
        logic [9:0] wd;
        wr0_v = w0v; wr0_addr = w0a; wr0_data = w0d;
        wr1_v = w1v; wr1_addr = w1a; wr1_data = w1d;
        rd_v = rv; rd_addr = ra; cfg_reinit = ri;
        #1;
        check("rsp_v", 32'(rd_rsp_v), 32'(pend_v));
        if (pend_v) check("rsp_data", 32'(rd_rsp_data), 32'(pend_d));
        if (!m_run) begin
            check("init_done_lo",  32'(init_done), 0);
            check("init_mem_we",   32'(mem_we),    1);
            check("init_waddr",    32'(mem_waddr), 32'(m_cnt));
            check("init_wdata",    32'(mem_wdata), 32'(INIT_VAL));
            check("init_wr0_rdy",  32'(wr0_ready), 0);
            check("init_wr1_rdy",  32'(wr1_ready), 0);
            check("init_rd_rdy",   32'(rd_ready),  0);
            check("init_mem_re",   32'(mem_re),    0);
            exp_mem[m_cnt[7:0]] = INIT_VAL;
            pend_v = 1'b0;
            if (ri) m_cnt = 0;
            else if (m_cnt == 255) begin m_run = 1'b1; m_cnt = 0; end
            else m_cnt++;
        end else begin
            if (ri) begin
                g0 = 1'b0; g1 = 1'b0; rdacc = 1'b0;
            end else begin
                g0 = w0v && (!w1v || !m_ptr);
                g1 = w1v && (!w0v || m_ptr);
                if (w0v && w1v) m_ptr = !m_ptr;
                rdacc = rv;
            end
            wa = g1 ? w1a : w0a;
            wd = g1 ? w1d : w0d;
            check("init_done_hi", 32'(init_done), 1);
            check("wr0_ready",    32'(wr0_ready), 32'(g0));
            check("wr1_ready",    32'(wr1_ready), 32'(g1));
            check("rd_ready",     32'(rd_ready),  32'(!ri));
            check("mem_we",       32'(mem_we),    32'(g0 | g1));
            if (g0 | g1) begin
                check("mem_waddr", 32'(mem_waddr), 32'(wa));
                check("mem_wdata", 32'(mem_wdata), 32'(wd));
            end
            check("mem_re", 32'(mem_re), 32'(rdacc));
            if (rdacc) check("mem_raddr", 32'(mem_raddr), 32'(ra));
            pend_v = rdacc;
            if (rdacc) pend_d = ((g0 | g1) && wa == ra) ? wd : exp_mem[ra];
            if (g0 | g1) exp_mem[wa] = wd;
            if (ri) begin m_run = 1'b0; m_cnt = 0; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rand_drive(input int amax);
        drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, amax)), 10'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, amax)), 10'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, amax)), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_reinit = 1'b0;
        wr0_v = 1'b1; wr0_addr = 8'h05; wr0_data = 10'h3FF;
        wr1_v = 1'b1; wr1_addr = 8'h06; wr1_data = 10'h1FF;
        rd_v = 1'b1;  rd_addr = 8'h07;
        model_reset();

        // Reset held with requesters active: everything must be quiet.
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_checks();

        // Sweep after release: 256 writes of INIT_VAL in order, no readies.
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) rand_drive(255);

        // Write then read back through the RF.
        drive(1'b1, 8'h3C, 10'h2A5, 1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 10'h000, 1'b1, 8'h3C, 1'b0);
        idle();

        // Contention: grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 8'(8'h40 + i), 10'(10'h100 + i), 1'b1, 8'(8'h50 + i), 10'(10'h200 + i),
                  1'b0, 8'h00, 1'b0);

        // Same-cycle write and read of one address: response takes the written data.
        drive(1'b0, 8'h00, 10'h000, 1'b1, 8'h10, 10'h155, 1'b1, 8'h10, 1'b0);
        idle();

        // Random traffic over a narrow address window to provoke collisions.
        for (int i = 0; i < 200; i++) rand_drive(15);
        idle();

        // Reinit with a read in flight; grants and reads blocked in the reinit cycle.
        drive(1'b1, 8'h20, 10'h3FF, 1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 10'h000, 1'b1, 8'h20, 1'b0);
        drive(1'b1, 8'h20, 10'h111, 1'b1, 8'h21, 10'h222, 1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 256; i++) idle();
        drive(1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 10'h000, 1'b1, 8'h20, 1'b0);
        drive(1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 10'h000, 1'b1, 8'h3C, 1'b0);
        idle();

        // Reinit pulse during a sweep restarts the counter.
        drive(1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) idle();
        drive(1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 10'h000, 1'b0, 8'h00, 1'b1);

        // Reset at sweep cycle 100: outputs drop at once, sweep restarts from 0.
        for (int i = 0; i < 100; i++) idle();
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) rand_drive(255);

        for (int i = 0; i < 150; i++) rand_drive(15);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hqm_system_mem_rf_256x10_ctl.md
Name: hqm_system_mem_rf_256x10_ctl

Overview:
- Controller in front of the 256x10 two-port register file wrapper.
- After reset, and on a software request, it sequences an initialization sweep that writes INIT_VAL to all 256 entries.
- It then arbitrates round-robin between two write requesters and serves one read requester with a fixed-latency response.
- Same-cycle read/write to the same address is forwarded so requesters never see the RF collision behaviour.

Parameters:
- DEPTH, 256: entries; address width AW = 8.
- DWIDTH, 10: data width.
- INIT_VAL, 10'h000: value written during the init sweep.

Ports:
- clk  in  1  functional clock; drives both RF wclk and rclk.
- rst_n  in  1  asynchronous active-low reset.
- cfg_reinit  in  1  single-cycle pulse; restarts the init sweep.
- init_done  out  1  high when the RF is initialized and the block is in RUN.
- wr0_v / wr0_addr / wr0_data  in  1/8/10  write requester 0.
- wr0_ready  out  1  write 0 accepted this cycle.
- wr1_v / wr1_addr / wr1_data  in  1/8/10  write requester 1.
- wr1_ready  out  1  write 1 accepted this cycle.
- rd_v / rd_addr  in  1/8  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_rsp_v  out  1  read response valid.
- rd_rsp_data  out  10  read response data.
- mem_we / mem_waddr / mem_wdata  out  1/8/10  to RF write port.
- mem_re / mem_raddr  out  1/8  to RF read port.
- mem_rdata  in  10  RF read data, valid 1 clk after mem_re.

Behaviour:
- Reset values:
  - init_done, wr*_ready, rd_ready, rd_rsp_v, mem_we, mem_re: 0.
  - All address and data outputs: 0.
  - FSM state: INIT; init counter: 0; RR pointer: requester 0.
- FSM states: INIT, RUN.
- INIT (first cycle after rst_n deassertion):
  - Every cycle: mem_we=1, mem_waddr=cnt, mem_wdata=INIT_VAL; cnt increments.
  - When cnt==255 is written, go to RUN next cycle. Sweep takes exactly 256 cycles.
  - All readies are 0.
- RUN:
  - init_done=1. Transition to INIT (cnt=0) on cfg_reinit.
  - cfg_reinit during INIT restarts cnt at 0.
- Write arbitration (RUN only, combinational grant):
  - Only one requester valid: it is granted.
  - Both valid: the requester pointed to by rr_ptr is granted, and rr_ptr flips to the other requester.
  - Granted requester sees wrN_ready=1. mem_we/mem_waddr/mem_wdata are driven from the grantee in the same cycle; no write register stage.
- Read (RUN only):
  - rd_ready = ~cfg_reinit; reads are never stalled by writes.
  - On accept: mem_re=1, mem_raddr=rd_addr.
  - rd_rsp_v and rd_rsp_data follow exactly 1 clk later (registered valid, data from mem_rdata).
- Collision (read accepted and write granted to the same address in the same cycle):
  - mem_re is still driven.
  - Write data is captured into a bypass register, and rd_rsp_data takes the bypass value next cycle, not mem_rdata.
- Write then read of the same address in consecutive cycles needs no bypass (RF write-to-read satisfied).
- Reinit with a read in flight:
  - Response for a read accepted in the cycle before INIT is still delivered.
  - cfg_reinit in RUN blocks all grants that cycle.
- Address wrap: the init counter is 9 bits internally; the terminal condition is cnt[7:0]==8'hFF. There is no wrap into a second sweep.
- Widths: all addresses are 8 bits; no arithmetic beyond the counter increment.

Decomposition:
- Package hqm_system_mem_ctl_pkg holds:
  - the FSM state enum (INIT, RUN);
  - localparams AW=8 and DWIDTH=10;
  - the typedef for the write request struct {addr, data}.
- One sub-module: hqm_system_mem_rr_arb2, the 2-input round-robin arbiter (req[1:0], gnt[1:0], pointer register). It is reusable for other RF controllers.

Test Plan:
1. Reset release: deassert rst_n → mem_we=1 for exactly 256 cycles, addresses 0..255 in order, data 10'h000; init_done rises on cycle 257; readies stay 0 throughout.
2. Write/read: write addr 8'h3C data 10'h2A5 via wr0, then read 8'h3C → rd_rsp_v is 1 clk after rd_ready and rd_rsp_data=10'h2A5.
3. Contention: wr0_v and wr1_v held high for 4 cycles → grants alternate 0,1,0,1; after reset the first grant goes to wr0.
4. Collision: in one cycle, wr1 writes 8'h10 with 10'h155 and a read of 8'h10 is issued (RF model returns X/old data) → rd_rsp_data=10'h155.
5. Reinit mid-run: read accepted at cycle t, cfg_reinit pulsed at t+1 → response delivered at t+1; init_done=0 from t+2; a new 256-cycle sweep runs; a previously written location reads INIT_VAL afterwards.
6. Reset mid-sweep: assert rst_n low at sweep cycle 100 → all outputs go to 0 immediately; after release the sweep restarts from addr 0.
